// File: rtl/loop_buffer_ctrl.sv
// Loop buffer controller: records audio samples into a sync BRAM and
// plays the captured loop back, wrapping at the committed loop length.
module loop_buffer_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic              play_en,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] sample_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              rec_done,
    output logic              play_wrap,
    output logic [ADDR_W:0]   loop_len
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] FULL_LEN  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        REC,
        FULL,
        PLAY
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            rd_p1;
    logic            rd_p2;

    logic rec_start;
    logic rec_wr;
    logic rec_last;
    logic rec_stop;
    logic play_start;
    logic play_rd;
    logic play_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rec_start  = 1'b0;
        rec_wr     = 1'b0;
        rec_last   = 1'b0;
        rec_stop   = 1'b0;
        play_start = 1'b0;
        play_rd    = 1'b0;
        play_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rec_en) begin
                    state_nx  = REC;
                    rec_start = 1'b1;
                end else if (play_en) begin
                    state_nx   = PLAY;
                    play_start = 1'b1;
                end
            end
            REC: begin
                if (!rec_en) begin
                    rec_stop = 1'b1;
                    if (play_en) begin
                        state_nx   = PLAY;
                        play_start = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (sample_tick) begin
                    rec_wr = 1'b1;
                    if (wr_ptr == LAST_ADDR) begin
                        rec_last = 1'b1;
                        state_nx = FULL;
                    end
                end
            end
            FULL: begin
                if (!rec_en) begin
                    if (play_en) begin
                        state_nx   = PLAY;
                        play_start = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            PLAY: begin
                if (rec_en) begin
                    state_nx  = REC;
                    rec_start = 1'b1;
                end else if (!play_en) begin
                    state_nx = IDLE;
                end else if (sample_tick && loop_len != '0) begin
                    play_rd   = 1'b1;
                    play_last = (rd_ptr == loop_len - ONE);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pointers and the committed loop length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            loop_len <= '0;
        end else begin
            if (rec_start) begin
                wr_ptr   <= '0;
                loop_len <= '0;
            end
            if (rec_wr) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rec_last) begin
                loop_len <= FULL_LEN;
            end
            if (rec_stop) begin
                loop_len <= wr_ptr;
            end
            if (play_start) begin
                rd_ptr <= '0;
            end
            if (play_rd) begin
                rd_ptr <= play_last ? '0 : rd_ptr + ONE;
            end
        end
    end

    // BRAM port: writes while recording, reads while playing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rec_done  <= 1'b0;
            play_wrap <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            rec_done  <= rec_last;
            play_wrap <= play_last;
            if (rec_wr) begin
                mem_we    <= 1'b1;
                mem_addr  <= wr_ptr[ADDR_W-1:0];
                mem_wdata <= sample_in;
            end
            if (play_rd) begin
                mem_addr <= rd_ptr[ADDR_W-1:0];
            end
        end
    end

    // Read pipeline: address cycle, BRAM data cycle, then output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p1        <= 1'b0;
            rd_p2        <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            rd_p1        <= play_rd;
            rd_p2        <= rd_p1;
            sample_valid <= rd_p2;
            if (rd_p2) begin
                sample_out <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_loop_buffer_ctrl.sv
// Bench for loop_buffer_ctrl: spec-level model with per-cycle compare
// plus literal expectations for the directed scenarios.
module tb_loop_buffer_ctrl;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rec_en = 1'b0;
    logic          play_en = 1'b0;
    logic          sample_tick = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic          rec_done;
    logic          play_wrap;
    logic [AW:0]   loop_len;

    loop_buffer_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .rec_en(rec_en),
        .play_en(play_en),
        .sample_tick(sample_tick),
        .sample_in(sample_in),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .rec_done(rec_done),
        .play_wrap(play_wrap),
        .loop_len(loop_len)
    );

    always #5 clk = ~clk;

    // External synchronous BRAM
    logic [DW-1:0] bram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Spec-level model: expected events keyed by cycle number
    typedef enum int { M_IDLE, M_REC, M_FULL, M_PLAY } mode_t;
    mode_t m_mode = M_IDLE;
    int m_len = 0;
    int wcount = 0;
    int rd = 0;
    logic [DW-1:0] loop_data [DEPTH];

    bit            exp_we   [int];
    bit            exp_rd   [int];
    bit            exp_done [int];
    bit            exp_wrap [int];
    bit            exp_val  [int];
    int            exp_addr [int];
    logic [DW-1:0] exp_wd   [int];
    logic [DW-1:0] exp_out  [int];
    int            exp_len  [int];

    task automatic set_len(input int c, input int v);
        exp_len[c] = v;
        m_len = v;
    endtask

    task automatic model_clear();
        exp_we.delete(); exp_rd.delete(); exp_done.delete();
        exp_wrap.delete(); exp_val.delete(); exp_addr.delete();
        exp_wd.delete(); exp_out.delete(); exp_len.delete();
        m_mode = M_IDLE; m_len = 0; wcount = 0; rd = 0;
    endtask

    task automatic step(input bit r, input bit p, input bit t, input logic [DW-1:0] d);
        int n;
        n = cyc;
        rec_en = r; play_en = p; sample_tick = t; sample_in = t ? d : '0;
        case (m_mode)
            M_IDLE: begin
                if (r) begin m_mode = M_REC; wcount = 0; set_len(n + 1, 0); end
                else if (p) begin m_mode = M_PLAY; rd = 0; end
            end
            M_REC: begin
                if (!r) begin
                    set_len(n + 1, wcount);
                    m_mode = p ? M_PLAY : M_IDLE;
                    rd = 0;
                end else if (t) begin
                    exp_we[n + 1] = 1'b1;
                    exp_addr[n + 1] = wcount;
                    exp_wd[n + 1] = d;
                    loop_data[wcount] = d;
                    if (wcount == DEPTH - 1) begin
                        exp_done[n + 1] = 1'b1;
                        set_len(n + 1, DEPTH);
                        m_mode = M_FULL;
                    end
                    wcount++;
                end
            end
            M_FULL: begin
                if (!r) begin m_mode = p ? M_PLAY : M_IDLE; rd = 0; end
            end
            M_PLAY: begin
                if (r) begin m_mode = M_REC; wcount = 0; set_len(n + 1, 0); end
                else if (!p) m_mode = M_IDLE;
                else if (t && m_len > 0) begin
                    exp_rd[n + 1] = 1'b1;
                    exp_addr[n + 1] = rd;
                    exp_val[n + 3] = 1'b1;
                    exp_out[n + 3] = loop_data[rd];
                    if (rd == m_len - 1) begin
                        exp_wrap[n + 1] = 1'b1;
                        rd = 0;
                    end else begin
                        rd++;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model
    logic [DW-1:0] cur_out = '0;
    int cur_len = 0;
    int n_val = 0, n_wrap = 0, n_done = 0, n_we = 0;
    logic [DW-1:0] outs [$];
    int val_cycs [$];

    always @(negedge clk) begin
        if (rst) begin
            cur_out = '0;
            cur_len = 0;
        end
        if (exp_out.exists(cyc)) cur_out = exp_out[cyc];
        if (exp_len.exists(cyc)) cur_len = exp_len[cyc];
        chk("mem_we", mem_we, exp_we.exists(cyc));
        chk("rec_done", rec_done, exp_done.exists(cyc));
        chk("play_wrap", play_wrap, exp_wrap.exists(cyc));
        chk("sample_valid", sample_valid, exp_val.exists(cyc));
        chk("sample_out", sample_out, cur_out);
        chk("loop_len", loop_len, cur_len);
        if (exp_we.exists(cyc) || exp_rd.exists(cyc)) chk("mem_addr", mem_addr, exp_addr[cyc]);
        if (exp_we.exists(cyc)) chk("mem_wdata", mem_wdata, exp_wd[cyc]);
        if (sample_valid) begin n_val++; outs.push_back(sample_out); val_cycs.push_back(cyc); end
        if (play_wrap) n_wrap++;
        if (rec_done) n_done++;
        if (mem_we) n_we++;
    end

    task automatic idle(input int k, input bit p);
        for (int i = 0; i < k; i++) step(1'b0, p, 1'b0, '0);
    endtask

    int b_val, b_wrap, b_done, b_we, tick_cyc;
    logic [DW-1:0] want;

    initial begin
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_loop_len", loop_len, 0);
        chk("reset_sample_out", sample_out, 0);
        rst = 1'b0;

        // Play with an empty loop
        b_val = n_val; b_we = n_we;
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h5500 + 16'(i));
            step(1'b0, 1'b1, 1'b0, '0);
        end
        idle(3, 1'b1);
        chk("empty_valid_cnt", n_val - b_val, 0);
        chk("empty_we_cnt", n_we - b_we, 0);
        chk("empty_sample_out", sample_out, 0);

        // Record 5, play 12 with wrap
        idle(1, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0);
        b_we = n_we;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'hA000 + 16'(i));
            step(1'b1, 1'b0, 1'b0, '0);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("t1_loop_len", loop_len, 5);
        chk("t1_we_cnt", n_we - b_we, 5);
        outs.delete(); val_cycs.delete();
        b_wrap = n_wrap;
        tick_cyc = cyc;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, '0);
            step(1'b0, 1'b1, 1'b0, '0);
            step(1'b0, 1'b1, 1'b0, '0);
        end
        idle(4, 1'b1);
        chk("t1_wrap_cnt", n_wrap - b_wrap, 2);
        chk("t1_out_cnt", outs.size(), 12);
        for (int i = 0; i < 12 && i < outs.size(); i++) begin
            want = 16'hA000 + 16'(i % 5);
            chk("t1_out_seq", outs[i], want);
        end
        if (val_cycs.size() > 0) chk("latency", val_cycs[0] - tick_cyc, 3);
        else chk("latency_no_valid", 0, 1);

        // Record 10 back-to-back into an 8-deep buffer
        idle(1, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0);
        b_we = n_we; b_done = n_done;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 16'hB000 + 16'(i));
        idle(0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("t2_we_cnt", n_we - b_we, 8);
        chk("t2_done_cnt", n_done - b_done, 1);
        chk("t2_loop_len", loop_len, 8);
        idle(1, 1'b0);

        // rec_en and play_en together: record wins
        b_we = n_we; b_val = n_val;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 16'hC000);
        step(1'b1, 1'b1, 1'b1, 16'hC001);
        idle(4, 1'b0);
        chk("t6_we_cnt", n_we - b_we, 2);
        chk("t6_val_cnt", n_val - b_val, 0);
        chk("t6_loop_len", loop_len, 2);

        // Async reset in the middle of a recording
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'hD000 + 16'(i));
        #2;
        chk("pre_rst_we", mem_we, 1);
        rst = 1'b1;
        rec_en = 1'b0; sample_tick = 1'b0;
        model_clear();
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_loop_len", loop_len, 0);
        chk("rst_done", rec_done, 0);
        chk("rst_sample_out", sample_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Re-record two samples and loop them
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 16'hE000);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 16'hE001);
        step(1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("t5_loop_len", loop_len, 2);
        outs.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, '0);
            step(1'b0, 1'b1, 1'b0, '0);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        idle(4, 1'b0);
        chk("t5_out_cnt", outs.size(), 5);
        for (int i = 0; i < 5 && i < outs.size(); i++) begin
            want = 16'hE000 + 16'(i % 2);
            chk("t5_out_seq", outs[i], want);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
